branch_update_queue: RTL and testbench

In-order queue of in-flight branch predictions sitting between fetch and execute. It is the update side of the 2-bit saturating-counter predictor. Fetch pushes each predicted branch with its pattern-history-table (PHT) index and the counter value read at prediction time. Execute resolves the oldest entry, and the block then issues a registered PHT write-back, flags mispredictions, and discards wrong-path entries.

---
 rtl/branch_update_queue.sv | 152 +++++++++++++++
 tb/tb_branch_update_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_queue.sv
// Update side of a 2-bit saturating-counter branch predictor: in-order queue of
// predicted branches, resolved at the head, with PHT write-back and wrong-path flush.
module branch_update_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic [IDX_W-1:0]         pred_idx,
  input  logic [1:0]               pred_state,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_idx,
  output logic [1:0]               upd_state,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [1:0] sat_step(input logic [1:0] s, input logic taken);
    logic [1:0] r;
    r = s;
    case ({taken, s})
      3'b1_00: r = 2'b01;
      3'b1_01: r = 2'b10;
      3'b1_10: r = 2'b11;
      3'b1_11: r = 2'b11;
      3'b0_11: r = 2'b10;
      3'b0_10: r = 2'b01;
      3'b0_01: r = 2'b00;
      3'b0_00: r = 2'b00;
      default: r = s;
    endcase
    return r;
  endfunction

  logic [IDX_W-1:0] idx_q  [DEPTH];
  logic [1:0]       st_q   [DEPTH];
  logic             pdir_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic             upd_valid_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic [1:0]       upd_state_q;
  logic             mispredict_q;

  logic             do_res_s;
  logic             do_push_s;
  logic             mis_s;
  logic [IDX_W-1:0] head_idx_s;
  logic [1:0]       new_st_s;
  logic [1:0]       push_st_s;

  // Resolve/push decisions, forwarded write data and next pointer/count state
  always_comb begin
    head_idx_s = idx_q[rd_ptr_q];
    new_st_s   = sat_step(st_q[rd_ptr_q], res_taken);
    do_res_s   = res_valid && (count_q != {CNT_W{1'b0}});
    mis_s      = do_res_s && (res_taken != pdir_q[rd_ptr_q]);
    // A same-cycle push on the wrong path is discarded along with the flushed entries.
    do_push_s  = pred_valid && ready_q && !mis_s;
    if (do_res_s && (pred_idx == head_idx_s)) begin
      push_st_s = new_st_s;
    end else begin
      push_st_s = pred_state;
    end

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (mis_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wr_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_res_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_res_s);
    end
  end

  // Entry storage: forwarding of the resolved counter, then the new push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i]  <= {IDX_W{1'b0}};
        st_q[i]   <= 2'b00;
        pdir_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_res_s && (idx_q[i] == head_idx_s)) begin
          st_q[i] <= new_st_s;
        end
      end
      if (do_push_s) begin
        idx_q[wr_ptr_q]  <= pred_idx;
        st_q[wr_ptr_q]   <= push_st_s;
        pdir_q[wr_ptr_q] <= pred_state[1];
      end
    end
  end

  // Pointers, occupancy and the registered PHT write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q     <= {PTR_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      ready_q      <= 1'b1;
      upd_valid_q  <= 1'b0;
      upd_idx_q    <= {IDX_W{1'b0}};
      upd_state_q  <= 2'b00;
      mispredict_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      ready_q      <= (count_d != CNT_W'(DEPTH));
      upd_valid_q  <= do_res_s;
      mispredict_q <= mis_s;
      if (do_res_s) begin
        upd_idx_q   <= head_idx_s;
        upd_state_q <= new_st_s;
      end
    end
  end

  assign pred_ready = ready_q;
  assign upd_valid  = upd_valid_q;
  assign upd_idx    = upd_idx_q;
  assign upd_state  = upd_state_q;
  assign mispredict = mispredict_q;
  assign count      = count_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: queue-based reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_branch_update_queue;

  localparam int DEPTH = 4;
  localparam int IDX_W = 6;

  logic             clk;
  logic             rst;
  logic             pred_valid;
  logic             pred_ready;
  logic [IDX_W-1:0] pred_idx;
  logic [1:0]       pred_state;
  logic             res_valid;
  logic             res_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_state;
  logic             mispredict;
  logic [2:0]       count;

  branch_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_idx(pred_idx), .pred_state(pred_state),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_state(upd_state),
    .mispredict(mispredict), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [1:0]       st;
    bit               pdir;
  } ent_t;

  ent_t             mq[$];
  bit               exp_uv;
  bit               exp_mis;
  logic [IDX_W-1:0] exp_uidx;
  logic [1:0]       exp_ust;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [1:0] model_sat(input logic [1:0] s, input bit t);
    int v;
    v = int'(s) + (t ? 1 : -1);
    if (v < 0) v = 0;
    if (v > 3) v = 3;
    return 2'(v);
  endfunction

  // Reference model: list of outstanding predictions, advanced at each edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      exp_uv = 0; exp_mis = 0; exp_uidx = '0; exp_ust = 2'b00;
    end else begin
      bit   res, ready, mis;
      ent_t h, e;
      logic [1:0] nst;
      res   = res_valid && (mq.size() != 0);
      ready = (mq.size() != DEPTH);
      mis   = 0;
      nst   = 2'b00;
      exp_uv = res;
      if (res) begin
        h   = mq.pop_front();
        nst = model_sat(h.st, res_taken);
        mis = (res_taken != h.pdir);
        exp_uidx = h.idx;
        exp_ust  = nst;
        if (mis) mq.delete();
        else foreach (mq[i]) if (mq[i].idx == h.idx) mq[i].st = nst;
      end
      exp_mis = mis;
      if (pred_valid && ready && !mis) begin
        e.idx  = pred_idx;
        e.pdir = pred_state[1];
        e.st   = (res && pred_idx == h.idx) ? nst : pred_state;
        mq.push_back(e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    check("count", 32'(count), 32'(mq.size()));
    check("pred_ready", 32'(pred_ready), 32'(mq.size() != DEPTH));
    check("upd_valid", 32'(upd_valid), 32'(exp_uv));
    check("mispredict", 32'(mispredict), 32'(exp_mis));
    if (exp_uv) begin
      check("upd_idx", 32'(upd_idx), 32'(exp_uidx));
      check("upd_state", 32'(upd_state), 32'(exp_ust));
    end
  endtask

  task automatic cyc(input bit pv, input int pidx, input logic [1:0] pst,
                     input bit rv, input bit rt);
    pred_valid = pv; pred_idx = IDX_W'(pidx); pred_state = pst;
    res_valid = rv; res_taken = rt;
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic push(input int pidx, input logic [1:0] pst);
    cyc(1, pidx, pst, 0, 0);
  endtask

  task automatic resolve(input bit rt);
    cyc(0, 0, 2'b00, 1, rt);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 0, 0);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    pred_valid = 0; pred_idx = '0; pred_state = 2'b00; res_valid = 0; res_taken = 0;
    #2;
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(pred_ready), 32'd1);
    check("rst_upd_valid", 32'(upd_valid), 32'd0);
    check("rst_upd_idx", 32'(upd_idx), 32'd0);
    check("rst_upd_state", 32'(upd_state), 32'd0);
    check("rst_mispredict", 32'(mispredict), 32'd0);

    // Single entry, predicted not-taken, resolves taken
    push(5, 2'b01);
    resolve(1);
    check("t1_uv", 32'(upd_valid), 32'd1);
    check("t1_idx", 32'(upd_idx), 32'd5);
    check("t1_state", 32'(upd_state), 32'd2);
    check("t1_mis", 32'(mispredict), 32'd1);
    check("t1_count", 32'(count), 32'd0);

    // Mispredict flushes younger entries and drops the same-cycle push
    push(3, 2'b11); push(3, 2'b11); push(7, 2'b10);
    cyc(1, 7, 2'b00, 1, 0);
    check("t2_state", 32'(upd_state), 32'd2);
    check("t2_mis", 32'(mispredict), 32'd1);
    check("t2_count", 32'(count), 32'd0);
    cyc(0, 0, 2'b00, 0, 0);
    check("t2_quiet", 32'(upd_valid), 32'd0);
    resolve(1);
    check("t2_empty_res", 32'(upd_valid), 32'd0);

    // Forwarding to a queued entry with the same index
    push(9, 2'b10); push(9, 2'b10);
    resolve(1);
    check("t3a_state", 32'(upd_state), 32'd3);
    resolve(1);
    check("t3b_state", 32'(upd_state), 32'd3);
    check("t3b_mis", 32'(mispredict), 32'd0);
    push(9, 2'b10); push(9, 2'b01);
    resolve(1);
    resolve(1);
    check("t3c_fwd_state", 32'(upd_state), 32'd3);
    check("t3c_mis", 32'(mispredict), 32'd1);

    // Forwarding into a same-cycle push
    push(4, 2'b10);
    cyc(1, 4, 2'b00, 1, 1);
    check("t3d_count", 32'(count), 32'd1);
    resolve(0);
    check("t3d_state", 32'(upd_state), 32'd2);
    check("t3d_mis", 32'(mispredict), 32'd0);

    // Full queue refuses a push even alongside a resolve; pointer wrap
    do_reset();
    push(1, 2'b10); push(2, 2'b10); push(3, 2'b10); push(4, 2'b10);
    check("t4_full_ready", 32'(pred_ready), 32'd0);
    check("t4_full_count", 32'(count), 32'd4);
    cyc(1, 6, 2'b10, 1, 1);
    check("t4_refused_count", 32'(count), 32'd3);
    check("t4_idx", 32'(upd_idx), 32'd1);
    push(8, 2'b10);
    check("t4_wrap_count", 32'(count), 32'd4);
    resolve(1); resolve(1); resolve(1); resolve(1);
    check("t4_wrap_idx", 32'(upd_idx), 32'd8);
    check("t4_drain", 32'(count), 32'd0);
    // Push and correct resolve together keep count steady
    push(10, 2'b10);
    cyc(1, 11, 2'b11, 1, 1);
    check("t4_steady", 32'(count), 32'd1);
    resolve(1);

    // Saturation at both ends
    push(2, 2'b00);
    resolve(0);
    check("t5_sat_lo", 32'(upd_state), 32'd0);
    push(2, 2'b11);
    resolve(1);
    check("t5_sat_hi", 32'(upd_state), 32'd3);
    check("t5_mis", 32'(mispredict), 32'd0);

    // Asynchronous reset with a resolve pending
    push(5, 2'b10); push(6, 2'b10);
    check("t6_pre", 32'(count), 32'd2);
    pred_valid = 0; res_valid = 1; res_taken = 1;
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    compare_model();
    check("t6_uv", 32'(upd_valid), 32'd0);
    check("t6_ready", 32'(pred_ready), 32'd1);
    rst = 1'b1;
    cyc(0, 0, 2'b00, 1, 1);
    check("t6_after", 32'(upd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
